// File: rtl/bcd_to_binary.sv
// Iterative reverse double-dabble: packed BCD digits plus sign -> unsigned magnitude
// and a saturated two's-complement operand for the signed multiplier.
module bcd_to_binary #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned OUT_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid,
  input  logic [4*DIGITS-1:0]   BCD_code,
  input  logic                  sign,
  output logic                  busy,
  output logic                  bin_ready,
  output logic [BIN_W-1:0]      magnitude,
  output logic [OUT_W-1:0]      result,
  output logic                  overflow,
  output logic                  digit_error
);

  localparam int unsigned WORK_W  = 4*DIGITS + BIN_W;
  localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_POS = (32'd1 << (OUT_W - 1)) - 32'd1;

  typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                sign_q;
  logic                busy_q, bin_ready_q, overflow_q, digit_error_q;
  logic [BIN_W-1:0]    magnitude_q;
  logic [OUT_W-1:0]    result_q, result_d;
  logic                overflow_d;
  logic                digit_bad;
  logic [BIN_W-1:0]    bin;
  logic [OUT_W-1:0]    mag_lo;

  assign bin    = work_q[BIN_W-1:0];
  assign mag_lo = bin[OUT_W-1:0];

  // One reverse-dabble step: shift right, then pull every BCD nibble >= 8 back by 3.
  always_comb begin
    work_d    = work_q >> 1;
    digit_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (work_d[BIN_W + 4*i +: 4] >= 4'd8)
        work_d[BIN_W + 4*i +: 4] = work_d[BIN_W + 4*i +: 4] - 4'd3;
      if (work_q[BIN_W + 4*i +: 4] > 4'd9)
        digit_bad = 1'b1;
    end
  end

  // Saturating signed mapping; negation of a value <= MAX+1 is exact in OUT_W bits.
  always_comb begin
    overflow_d = 1'b0;
    result_d   = '0;
    if (!sign_q) begin
      overflow_d = 32'(bin) > MAX_POS;
      result_d   = overflow_d ? {1'b0, {(OUT_W-1){1'b1}}} : mag_lo;
    end else begin
      overflow_d = 32'(bin) > MAX_POS + 32'd1;
      result_d   = overflow_d ? {1'b1, {(OUT_W-1){1'b0}}} : '0 - mag_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      work_q        <= '0;
      cnt_q         <= '0;
      sign_q        <= 1'b0;
      busy_q        <= 1'b0;
      bin_ready_q   <= 1'b0;
      magnitude_q   <= '0;
      result_q      <= '0;
      overflow_q    <= 1'b0;
      digit_error_q <= 1'b0;
    end else begin
      bin_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid) begin
            work_q  <= {BCD_code, {BIN_W{1'b0}}};
            sign_q  <= sign;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (digit_bad) begin
            digit_error_q <= 1'b1;
            magnitude_q   <= '0;
            result_q      <= '0;
            overflow_q    <= 1'b0;
            state_q       <= DONE;
          end else begin
            digit_error_q <= 1'b0;
            cnt_q         <= '0;
            state_q       <= SHIFT;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1))
            state_q <= DONE;
        end
        DONE: begin
          if (!digit_error_q) begin
            magnitude_q <= bin;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
          end
          bin_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign bin_ready   = bin_ready_q;
  assign magnitude   = magnitude_q;
  assign result      = result_q;
  assign overflow    = overflow_q;
  assign digit_error = digit_error_q;

endmodule
